// File: rtl/data_frame_parser.sv
// Receiver for header/data/footer framed 64-bit words: strips framing, forwards payload
// through a single output register, and reports per-frame info and error statistics.
module data_frame_parser #(
    parameter int         DIN_WIDTH              = 64,
    parameter int         MAX_FRAME_LENGTH       = 200,
    parameter int         TIME_STAMP_WIDTH       = 48,
    parameter int         FIRST_TIME_STAMP_WIDTH = 24,
    parameter logic [7:0] HEADER_ID              = 8'hAA,
    parameter logic [7:0] FOOTER_ID              = 8'h55
) (
    input  logic                        CLK,
    input  logic                        RESETN,
    input  logic                        iVALID,
    output logic                        oREADY,
    input  logic [DIN_WIDTH-1:0]        DIN,
    output logic                        oVALID,
    input  logic                        iREADY,
    output logic [DIN_WIDTH-1:0]        DOUT,
    output logic                        oLAST,
    output logic                        INFO_VALID,
    output logic [7:0]                  INFO_CHANNEL,
    output logic [TIME_STAMP_WIDTH-1:0] INFO_TIMESTAMP,
    output logic [7:0]                  INFO_LENGTH,
    output logic [1:0]                  INFO_ERR,
    output logic [31:0]                 FRAME_CNT,
    output logic [15:0]                 ERR_CNT
);

    localparam int         LP_HI_TS_W = TIME_STAMP_WIDTH - FIRST_TIME_STAMP_WIDTH;
    localparam logic [7:0] LP_MAX_LEN = 8'(MAX_FRAME_LENGTH);

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_DATA,
        ST_FOOTER
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [7:0]                        r_channel;
    logic [7:0]                        r_length;
    logic [FIRST_TIME_STAMP_WIDTH-1:0] r_tsLo;
    logic [7:0]                        r_count;

    logic                              r_outValid;
    logic                              r_outLast;
    logic [DIN_WIDTH-1:0]              r_outData;

    logic                              r_infoValid;
    logic [7:0]                        r_infoChannel;
    logic [TIME_STAMP_WIDTH-1:0]       r_infoTimestamp;
    logic [7:0]                        r_infoLength;
    logic [1:0]                        r_infoErr;
    logic [31:0]                       r_frameCnt;
    logic [15:0]                       r_errCnt;

    logic       w_ready;
    logic       w_accept;
    logic [7:0] w_marker;
    logic [7:0] w_hdrLength;
    logic       w_isHeader;
    logic       w_lengthOk;
    logic       w_footMarkErr;
    logic       w_lenErr;
    logic       w_hdrGood;
    logic       w_hdrBad;
    logic       w_dataTake;
    logic       w_footTake;
    logic       w_unused;

    assign w_marker      = DIN[63:56];
    assign w_hdrLength   = DIN[47:40];
    assign w_isHeader    = (w_marker == HEADER_ID);
    assign w_lengthOk    = (w_hdrLength != 8'd0) && (w_hdrLength <= LP_MAX_LEN);
    assign w_footMarkErr = (w_marker != FOOTER_ID);
    assign w_lenErr      = ~w_footMarkErr & (DIN[31:24] != r_length);
    assign w_unused      = ^DIN[15:0];

    // Only the data phase is throttled by the output register; framing words are always taken.
    assign w_ready  = (r_state == ST_DATA) ? (~r_outValid | iREADY) : 1'b1;
    assign w_accept = iVALID & w_ready;

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            r_state <= ST_HUNT;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_hdrGood   = 1'b0;
        w_hdrBad    = 1'b0;
        w_dataTake  = 1'b0;
        w_footTake  = 1'b0;
        case (r_state)
            ST_HUNT: begin
                if (w_accept && w_isHeader) begin
                    if (w_lengthOk) begin
                        w_hdrGood   = 1'b1;
                        w_nextState = ST_DATA;
                    end else begin
                        w_hdrBad = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (w_accept) begin
                    w_dataTake = 1'b1;
                    if (r_count == 8'd1) begin
                        w_nextState = ST_FOOTER;
                    end
                end
            end
            ST_FOOTER: begin
                if (w_accept) begin
                    w_footTake  = 1'b1;
                    w_nextState = ST_HUNT;
                end
            end
            default: begin
                w_nextState = ST_HUNT;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            r_channel <= '0;
            r_length  <= '0;
            r_tsLo    <= '0;
            r_count   <= '0;
        end else if (w_hdrGood) begin
            r_channel <= DIN[55:48];
            r_length  <= w_hdrLength;
            r_tsLo    <= DIN[16 +: FIRST_TIME_STAMP_WIDTH];
            r_count   <= w_hdrLength;
        end else if (w_dataTake) begin
            r_count   <= r_count - 8'd1;
        end
    end

    // A stalled word keeps its data; the register empties only when the consumer takes it
    // and nothing new arrives on the same edge.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            r_outValid <= 1'b0;
            r_outLast  <= 1'b0;
            r_outData  <= '0;
        end else if (w_dataTake) begin
            r_outValid <= 1'b1;
            r_outLast  <= (r_count == 8'd1);
            r_outData  <= DIN;
        end else if (r_outValid && iREADY) begin
            r_outValid <= 1'b0;
            r_outLast  <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            r_infoValid     <= 1'b0;
            r_infoChannel   <= '0;
            r_infoTimestamp <= '0;
            r_infoLength    <= '0;
            r_infoErr       <= '0;
        end else begin
            r_infoValid <= w_footTake;
            if (w_footTake) begin
                r_infoChannel   <= r_channel;
                r_infoTimestamp <= {DIN[32 +: LP_HI_TS_W], r_tsLo};
                r_infoLength    <= r_length;
                r_infoErr       <= {w_lenErr, w_footMarkErr};
            end
        end
    end

    // Rejected headers and bad frames share the saturating error counter.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            r_frameCnt <= '0;
            r_errCnt   <= '0;
        end else begin
            if (w_footTake && !w_footMarkErr && !w_lenErr) begin
                r_frameCnt <= r_frameCnt + 32'd1;
            end
            if ((w_hdrBad || (w_footTake && (w_footMarkErr || w_lenErr))) && (r_errCnt != 16'hFFFF)) begin
                r_errCnt <= r_errCnt + 16'd1;
            end
        end
    end

    assign oREADY         = w_ready;
    assign oVALID         = r_outValid;
    assign oLAST          = r_outLast;
    assign DOUT           = r_outData;
    assign INFO_VALID     = r_infoValid;
    assign INFO_CHANNEL   = r_infoChannel;
    assign INFO_TIMESTAMP = r_infoTimestamp;
    assign INFO_LENGTH    = r_infoLength;
    assign INFO_ERR       = r_infoErr;
    assign FRAME_CNT      = r_frameCnt;
    assign ERR_CNT        = r_errCnt;

endmodule

// File: tb/tb_data_frame_parser.sv
// Directed bench for data_frame_parser: expected data words and frame info are queued as
// frames are driven and compared when the parser emits them.
module tb_data_frame_parser;

    typedef struct {
        logic [7:0]  ch;
        logic [47:0] ts;
        logic [7:0]  len;
        logic [1:0]  err;
        logic [31:0] fc;
        logic [15:0] ec;
    } info_t;

    logic        CLK;
    logic        RESETN;
    logic        iVALID;
    logic        oREADY;
    logic [63:0] DIN;
    logic        oVALID;
    logic        iREADY;
    logic [63:0] DOUT;
    logic        oLAST;
    logic        INFO_VALID;
    logic [7:0]  INFO_CHANNEL;
    logic [47:0] INFO_TIMESTAMP;
    logic [7:0]  INFO_LENGTH;
    logic [1:0]  INFO_ERR;
    logic [31:0] FRAME_CNT;
    logic [15:0] ERR_CNT;

    int          numChecks = 0;
    int          numFails  = 0;
    logic [64:0] dataQ[$];
    info_t       infoQ[$];
    info_t       lastInfo;
    logic [31:0] mFrameCnt;
    logic [15:0] mErrCnt;
    bit          toggleMode;
    bit          latPending;
    logic [63:0] latWord;
    bit          prevStall;
    bit          prevInfo;
    logic [63:0] prevDout;

    data_frame_parser dut (
        .CLK(CLK), .RESETN(RESETN), .iVALID(iVALID), .oREADY(oREADY), .DIN(DIN),
        .oVALID(oVALID), .iREADY(iREADY), .DOUT(DOUT), .oLAST(oLAST),
        .INFO_VALID(INFO_VALID), .INFO_CHANNEL(INFO_CHANNEL), .INFO_TIMESTAMP(INFO_TIMESTAMP),
        .INFO_LENGTH(INFO_LENGTH), .INFO_ERR(INFO_ERR), .FRAME_CNT(FRAME_CNT), .ERR_CNT(ERR_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        numChecks++;
        assert (obs === exp) else begin
            numFails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        if (toggleMode) iREADY = ~iREADY;
    endtask

    // Every stimulus wait passes through here so the one-cycle latency check lands on the
    // first falling edge after a data word is accepted.
    task automatic waitNeg();
        @(negedge CLK);
        if (latPending) begin
            checkOutput("latency_ovalid", oVALID, 1);
            checkOutput("latency_dout", DOUT, latWord);
            latPending = 0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            waitNeg();
            tick();
        end
    endtask

    task automatic applyStimulus(input logic [63:0] w, input bit isData);
        int waited = 0;
        bit rdy;
        DIN    = w;
        iVALID = 1'b1;
        forever begin
            waitNeg();
            rdy = oREADY;
            if (isData) checkOutput("oready_data", oREADY, (!oVALID || iREADY));
            tick();
            if (rdy) break;
            waited++;
            if (waited > 200) begin
                checkOutput("accept_timeout", waited, 0);
                break;
            end
        end
        if (isData && rdy) begin
            latPending = 1;
            latWord    = w;
        end
        iVALID = 1'b0;
    endtask

    task automatic sendFrame(input logic [7:0] ch, input logic [7:0] len, input logic [23:0] tsLo,
                             input logic [23:0] tsHi, input logic [7:0] echo, input logic [7:0] footId);
        logic [63:0] w;
        info_t       e;
        bit          footErr;
        bit          lenErr;
        applyStimulus({8'hAA, ch, len, tsLo, 16'h0000}, 0);
        for (int i = 0; i < int'(len); i++) begin
            w = {$urandom, $urandom};
            dataQ.push_back({(i == int'(len) - 1), w});
            applyStimulus(w, 1);
        end
        footErr = (footId != 8'h55);
        lenErr  = !footErr && (echo != len);
        if (!footErr && !lenErr) mFrameCnt = mFrameCnt + 1;
        else if (mErrCnt != 16'hFFFF) mErrCnt = mErrCnt + 1;
        e.ch  = ch;
        e.ts  = {tsHi, tsLo};
        e.len = len;
        e.err = {lenErr, footErr};
        e.fc  = mFrameCnt;
        e.ec  = mErrCnt;
        infoQ.push_back(e);
        applyStimulus({footId, tsHi, echo, 24'h000000}, 0);
    endtask

    task automatic doReset();
        RESETN = 1'b0;
        iVALID = 1'b0;
        DIN    = '0;
        repeat (2) tick();
        dataQ.delete();
        infoQ.delete();
        latPending = 0;
        mFrameCnt  = 0;
        mErrCnt    = 0;
        waitNeg();
        checkOutput("rst_ovalid", oVALID, 0);
        checkOutput("rst_olast", oLAST, 0);
        checkOutput("rst_dout", DOUT, 0);
        checkOutput("rst_info_valid", INFO_VALID, 0);
        checkOutput("rst_info_channel", INFO_CHANNEL, 0);
        checkOutput("rst_info_ts", INFO_TIMESTAMP, 0);
        checkOutput("rst_info_length", INFO_LENGTH, 0);
        checkOutput("rst_info_err", INFO_ERR, 0);
        checkOutput("rst_frame_cnt", FRAME_CNT, 0);
        checkOutput("rst_err_cnt", ERR_CNT, 0);
        tick();
        RESETN = 1'b1;
        waitNeg();
        checkOutput("oready_after_reset", oREADY, 1);
        tick();
    endtask

    task automatic endScenario(input string name);
        toggleMode = 0;
        iREADY     = 1'b1;
        idle(8);
        checkOutput({name, "_dataq_empty"}, dataQ.size(), 0);
        checkOutput({name, "_infoq_empty"}, infoQ.size(), 0);
    endtask

    always @(negedge CLK) begin
        logic [64:0] expData;
        info_t       e;
        if (!RESETN) begin
            prevStall = 0;
            prevInfo  = 0;
        end else begin
            if (prevStall) begin
                checkOutput("stall_ovalid", oVALID, 1);
                checkOutput("stall_dout", DOUT, prevDout);
            end
            if (oVALID && iREADY) begin
                checkOutput("data_expected", dataQ.size() != 0, 1);
                if (dataQ.size() != 0) begin
                    expData = dataQ.pop_front();
                    checkOutput("dout", DOUT, expData[63:0]);
                    checkOutput("olast", oLAST, expData[64]);
                end
            end
            if (prevInfo) checkOutput("info_pulse_width", INFO_VALID, 0);
            if (INFO_VALID) begin
                checkOutput("info_expected", infoQ.size() != 0, 1);
                if (infoQ.size() != 0) begin
                    e = infoQ.pop_front();
                    lastInfo = e;
                    checkOutput("info_channel", INFO_CHANNEL, e.ch);
                    checkOutput("info_timestamp", INFO_TIMESTAMP, e.ts);
                    checkOutput("info_length", INFO_LENGTH, e.len);
                    checkOutput("info_err", INFO_ERR, e.err);
                    checkOutput("frame_cnt", FRAME_CNT, e.fc);
                    checkOutput("err_cnt", ERR_CNT, e.ec);
                end
            end
            prevStall = oVALID && !iREADY;
            prevDout  = DOUT;
            prevInfo  = INFO_VALID;
        end
    end

    initial begin
        logic [63:0] d1;
        logic [63:0] d2;
        RESETN     = 1'b0;
        iVALID     = 1'b0;
        iREADY     = 1'b1;
        DIN        = '0;
        toggleMode = 0;
        latPending = 0;
        doReset();

        $display("[TB] good frame followed back-to-back by a second frame");
        sendFrame(8'h03, 8'h03, 24'h123456, 24'hABCDEF, 8'h03, 8'h55);
        sendFrame(8'h07, 8'h02, 24'h000001, 24'hFEDCBA, 8'h02, 8'h55);
        endScenario("good");
        checkOutput("good_frame_cnt", FRAME_CNT, 2);

        $display("[TB] backpressure with toggling iREADY");
        doReset();
        toggleMode = 1;
        sendFrame(8'h03, 8'h03, 24'h123456, 24'hABCDEF, 8'h03, 8'h55);
        sendFrame(8'h11, 8'h05, 24'h0A0B0C, 24'h010203, 8'h05, 8'h55);
        endScenario("bp");

        $display("[TB] bad footer marker then good frame");
        doReset();
        sendFrame(8'h03, 8'h03, 24'h123456, 24'hABCDEF, 8'h03, 8'h54);
        sendFrame(8'h04, 8'h02, 24'h222222, 24'h333333, 8'h02, 8'h55);
        endScenario("badfoot");
        checkOutput("badfoot_err_cnt", ERR_CNT, 1);

        $display("[TB] length echo mismatch");
        doReset();
        sendFrame(8'h09, 8'h02, 24'h445566, 24'h778899, 8'h03, 8'h55);
        endScenario("lenerr");
        checkOutput("lenerr_frame_cnt", FRAME_CNT, 0);

        $display("[TB] hunt and resync");
        doReset();
        applyStimulus(64'h0123456789ABCDEF, 0);
        applyStimulus(64'h55ABCDEF03000000, 0);
        applyStimulus(64'hAB03031234560000, 0);
        applyStimulus(64'h0000000000000000, 0);
        applyStimulus(64'hFFFFFFFFFFFFFFFF, 0);
        applyStimulus(64'hAA01001234560000, 0);
        mErrCnt = mErrCnt + 1;
        applyStimulus(64'hAA01C91234560000, 0);
        mErrCnt = mErrCnt + 1;
        sendFrame(8'h01, 8'h01, 24'h654321, 24'h0FEDCB, 8'h01, 8'h55);
        endScenario("hunt");
        checkOutput("hunt_err_cnt", ERR_CNT, 2);
        checkOutput("hunt_frame_cnt", FRAME_CNT, 1);

        $display("[TB] reset in the middle of a frame");
        doReset();
        d1 = {$urandom, $urandom};
        d2 = {$urandom, $urandom};
        applyStimulus(64'hAA05041111110000, 0);
        dataQ.push_back({1'b0, d1});
        applyStimulus(d1, 1);
        dataQ.push_back({1'b0, d2});
        applyStimulus(d2, 1);
        iREADY = 1'b0;
        waitNeg();
        doReset();
        iREADY = 1'b1;
        sendFrame(8'h06, 8'h04, 24'h999999, 24'h888888, 8'h04, 8'h55);
        endScenario("midrst");
        checkOutput("midrst_frame_cnt", FRAME_CNT, 1);
        checkOutput("info_hold_ts", INFO_TIMESTAMP, lastInfo.ts);
        checkOutput("info_hold_len", INFO_LENGTH, lastInfo.len);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule

// File: doc/data_frame_parser.md
# data_frame_parser

Single-clock receiver for the 64-bit data-frame stream produced by the frame generator (header word, N data words, footer word). It sits downstream of the generator's read side, strips header and footer, and forwards data words with a last-word marker. It reassembles the 48-bit timestamp and reports per-frame info with error flags. After a malformed frame it resynchronises by hunting for the next header marker.

## Interface
Parameters:
- DIN_WIDTH, 64, frame word width (fixed at 64)
- MAX_FRAME_LENGTH, 200, max data words per frame
- TIME_STAMP_WIDTH, 48, full timestamp width
- FIRST_TIME_STAMP_WIDTH, 24, timestamp bits carried in header
- HEADER_ID, 8'hAA, header marker in bits [63:56]
- FOOTER_ID, 8'h55, footer marker in bits [63:56]

Ports:
- CLK  in  1  sole clock
- RESETN  in  1  synchronous, active-low reset
- iVALID  in  1  frame word valid
- oREADY  out  1  parser accepts frame word
- DIN  in  64  frame word
- oVALID  out  1  data word valid
- iREADY  in  1  downstream accepts data word
- DOUT  out  64  data word (4 samples, payload unmodified)
- oLAST  out  1  DOUT is last data word of frame
- INFO_VALID  out  1  one-cycle frame-info pulse
- INFO_CHANNEL  out  8  channel ID from header
- INFO_TIMESTAMP  out  48  {footer[55:32], header[39:16]}
- INFO_LENGTH  out  8  data-word count from header
- INFO_ERR  out  2  {LEN_ERR, FOOTER_ERR}
- FRAME_CNT  out  32  good frames (INFO_ERR==0)
- ERR_CNT  out  16  frames or headers rejected, saturating at 16'hFFFF

## Operation
- Header layout: [63:56] HEADER_ID, [55:48] channel, [47:40] length L, [39:16] timestamp low 24 bits, [15:0] ignored.
- Footer layout: [63:56] FOOTER_ID, [55:32] timestamp high 24 bits, [31:24] length echo, [23:0] ignored.
- State HUNT (reset state): oREADY=1. On accepted word:
  - If [63:56]==HEADER_ID and 1<=L<=MAX_FRAME_LENGTH: latch channel, L, and timestamp low; load the data counter with L; go to DATA.
  - If the marker matches but L is illegal: increment ERR_CNT and stay in HUNT. No INFO pulse.
  - Any other word: discard silently.
- State DATA: forward each accepted word to the output register and decrement the counter. The word accepted with counter==1 sets oLAST and moves to FOOTER.
- State FOOTER: oREADY=1. On accepted word:
  - FOOTER_ERR = marker!=FOOTER_ID.
  - LEN_ERR = echo!=L, evaluated only when the marker matches.
  - Pulse INFO_VALID with the latched fields. INFO_TIMESTAMP takes its high bits from the footer even when FOOTER_ERR is set.
  - Increment FRAME_CNT if no error, otherwise ERR_CNT.
  - Go to HUNT. A mismatched footer word is consumed, never reinterpreted as a header.
- FRAME_CNT wraps modulo 2^32. ERR_CNT saturates.

## Timing
- Output stage is one register. In DATA, oREADY = ~oVALID | iREADY; in HUNT and FOOTER, oREADY = 1.
- Data latency: DIN accepted at edge k gives DOUT/oVALID valid after edge k. It holds stable while oVALID & ~iREADY.
- oVALID drops after the edge where iREADY is high and no new data word is accepted.
- INFO_VALID asserts for exactly one cycle, after the edge accepting the footer. INFO_* fields hold until the next pulse.
- FRAME_CNT and ERR_CNT update on the same edge as INFO_VALID.
- A footer may be accepted while the last data word is still stalled in the output register. INFO_VALID may therefore precede the oLAST handshake.
- Back-to-back frames: a header may be accepted the cycle after the footer, with zero idle cycles.
- Reset values: oVALID=0, oLAST=0, DOUT=0, INFO_VALID=0, INFO_*=0, FRAME_CNT=0, ERR_CNT=0, state=HUNT.
- oREADY is 1 in the cycle after reset.
- Reset mid-frame drops the partial frame and any held output word. No INFO pulse and no counter change is produced for it.

## Test plan
- Good frame: header AA_03_03_123456_0000, 3 data words, footer 55_ABCDEF_03_000000, iREADY=1.
  - DOUT shows 3 words at 1-cycle latency; oLAST on the 3rd.
  - INFO_TIMESTAMP=48'hABCDEF123456, INFO_LENGTH=3, INFO_ERR=0, FRAME_CNT=1.
- Backpressure: same frame with iREADY toggling 1010…
  - No word lost or duplicated; DOUT held stable while stalled; oREADY=0 whenever oVALID & ~iREADY in DATA.
- Bad footer: marker 54 instead of 55.
  - INFO_ERR=2'b01, ERR_CNT=1, FRAME_CNT=0.
  - Following good frame parses correctly.
- Length echo mismatch: header L=2, footer echo 3.
  - INFO_ERR=2'b10, ERR_CNT=1.
- Hunt/resync: 5 garbage words, then a header with L=0, then a header with L=201, then a good L=1 frame.
  - ERR_CNT=2; garbage produces no output; exactly one INFO pulse with FRAME_CNT=1.
- Reset mid-frame: assert RESETN=0 after 2 of 4 data words.
  - All outputs return to reset values; a new complete frame parses normally with FRAME_CNT=1.
